// File: rtl/serial_mag_comparator.sv
`default_nettype none
// serial_mag_comparator: slice-serial '85-style magnitude comparator, MSB slice first, start/done handshake.
// Define SERIAL_CMP_SIGNED_EN to add the SIGNED input (two's-complement ordering of the MSB slice).
module serial_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             I_gr,
  input  logic             I_les,
  input  logic             I_eq,
`ifdef SERIAL_CMP_SIGNED_EN
  input  logic             SIGNED,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             A_gr_B,
  output logic             A_les_B,
  output logic             A_eq_B
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [2:0]       cas_q, cas_d;    // {I_gr, I_les, I_eq}
  logic [2:0]       flags_q, flags_d; // {A_gr_B, A_les_B, A_eq_B}
  logic [SLICE-1:0] slice_a, slice_b;
  logic             inv_msb;

`ifdef SERIAL_CMP_SIGNED_EN
  logic sgn_q, sgn_d;
  assign inv_msb = sgn_q && (idx_q == LAST_IDX);
`else
  assign inv_msb = 1'b0;
`endif

  // Operands shift up each equal slice, so the slice under test is always the top one.
  always_comb begin
    slice_a = a_q[WIDTH-1 -: SLICE];
    slice_b = b_q[WIDTH-1 -: SLICE];
    slice_a[SLICE-1] = slice_a[SLICE-1] ^ inv_msb;
    slice_b[SLICE-1] = slice_b[SLICE-1] ^ inv_msb;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cas_d   = cas_q;
    flags_d = flags_q;
`ifdef SERIAL_CMP_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      S_COMP: begin
        if (slice_a > slice_b) begin
          flags_d = 3'b100;
          state_d = S_DONE;
        end else if (slice_a < slice_b) begin
          flags_d = 3'b010;
          state_d = S_DONE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDXW'(1);
          a_d   = a_q << SLICE;
          b_d   = b_q << SLICE;
        end else begin
          flags_d = {~cas_q[0] & ~cas_q[1], ~cas_q[0] & ~cas_q[2], cas_q[0]};
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (START) begin
          state_d = S_COMP;
          a_d     = A;
          b_d     = B;
          cas_d   = {I_gr, I_les, I_eq};
          idx_d   = LAST_IDX;
`ifdef SERIAL_CMP_SIGNED_EN
          sgn_d   = SIGNED;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cas_q   <= '0;
      flags_q <= 3'b001;
`ifdef SERIAL_CMP_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cas_q   <= cas_d;
      flags_q <= flags_d;
`ifdef SERIAL_CMP_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign BUSY    = (state_q == S_COMP);
  assign DONE    = (state_q == S_DONE);
  assign A_gr_B  = flags_q[2];
  assign A_les_B = flags_q[1];
  assign A_eq_B  = flags_q[0];

endmodule
`default_nettype wire
